arm_control_unit: RTL and testbench

ARM_CONTROL_UNIT -- requirements
Module: arm_control_unit

---
 rtl/arm_control_unit.sv | 202 ++++++++++++++++++++
 tb/tb_arm_control_unit.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/arm_control_unit.sv
// Moore microsequencer for a simple ARM-subset datapath: 5-bit state register, CW decoded from state (plus IR fields).
// Optional macro CU_BRANCH_LINK_EN: a branch with IR[24]=1 writes R14 in a LINK state before BRANCH.
module arm_control_unit (
  input  logic        CLK,
  input  logic        Reset,
  input  logic [31:0] IR,
  input  logic        MFC,
  input  logic [3:0]  Flags,
  output logic [31:0] CW
);

  typedef enum logic [4:0] {
    S_RESET  = 5'd0,
    S_FETCH1 = 5'd1,
    S_FETCH2 = 5'd2,
    S_FETCH3 = 5'd3,
    S_DECODE = 5'd4,
    S_DP_REG = 5'd5,
    S_DP_IMM = 5'd6,
    S_ADDR   = 5'd7,
    S_LOAD   = 5'd8,
    S_WB     = 5'd9,
    S_STORE  = 5'd10,
    S_LINK   = 5'd11,
    S_BRANCH = 5'd12
  } state_t;

  localparam int B_MFA    = 31;
  localparam int B_RW_RAM = 30;
  localparam int B_RF_RW  = 28;
  localparam int B_SSAB   = 27;
  localparam int B_SSOP   = 26;
  localparam int B_SMA    = 25;
  localparam int B_STA    = 24;
  localparam int B_MAR_EN = 23;
  localparam int B_SR_EN  = 22;
  localparam int B_MDR_EN = 21;
  localparam int B_IR_EN  = 20;
  localparam int B_SHT_EN = 19;
  localparam int B_ISE_EN = 18;
  localparam int B_CLR    = 16;

  localparam logic [3:0] ALU_ADD = 4'b0100;
  localparam logic [3:0] ALU_SUB = 4'b0010;

  state_t      state_q, state_d;
  logic [31:0] cw;
  logic        cond_ok;
  logic        link_br;
  logic        fl_c, fl_n, fl_v, fl_z;
  logic        unused_ir;

  assign fl_c = Flags[3];
  assign fl_n = Flags[2];
  assign fl_v = Flags[1];
  assign fl_z = Flags[0];
  assign unused_ir = ^IR[19:0];

`ifdef CU_BRANCH_LINK_EN
  assign link_br = IR[24];
`else
  assign link_br = 1'b0;
`endif

  always_comb begin
    cond_ok = 1'b0;
    case (IR[31:28])
      4'b0000: cond_ok = fl_z;
      4'b0001: cond_ok = !fl_z;
      4'b0010: cond_ok = fl_c;
      4'b0011: cond_ok = !fl_c;
      4'b0100: cond_ok = fl_n;
      4'b0101: cond_ok = !fl_n;
      4'b0110: cond_ok = fl_v;
      4'b0111: cond_ok = !fl_v;
      4'b1000: cond_ok = fl_c && !fl_z;
      4'b1001: cond_ok = !fl_c || fl_z;
      4'b1010: cond_ok = (fl_n == fl_v);
      4'b1011: cond_ok = (fl_n != fl_v);
      4'b1100: cond_ok = !fl_z && (fl_n == fl_v);
      4'b1101: cond_ok = fl_z || (fl_n != fl_v);
      4'b1110: cond_ok = 1'b1;
      default: cond_ok = 1'b0;
    endcase
  end

  always_comb begin
    state_d = S_RESET;
    case (state_q)
      S_RESET:  state_d = S_FETCH1;
      S_FETCH1: state_d = S_FETCH2;
      S_FETCH2: state_d = S_FETCH3;
      S_FETCH3: state_d = MFC ? S_DECODE : S_FETCH3;
      S_DECODE: begin
        if (!cond_ok) begin
          state_d = S_FETCH1;
        end else begin
          case (IR[27:25])
            3'b000:  state_d = S_DP_REG;
            3'b001:  state_d = S_DP_IMM;
            3'b010:  state_d = S_ADDR;
            3'b101:  state_d = link_br ? S_LINK : S_BRANCH;
            default: state_d = S_FETCH1;
          endcase
        end
      end
      S_DP_REG: state_d = S_FETCH1;
      S_DP_IMM: state_d = S_FETCH1;
      S_ADDR:   state_d = IR[20] ? S_LOAD : S_STORE;
      S_LOAD:   state_d = MFC ? S_WB : S_LOAD;
      S_WB:     state_d = S_FETCH1;
      S_STORE:  state_d = MFC ? S_FETCH1 : S_STORE;
      S_LINK:   state_d = S_BRANCH;
      S_BRANCH: state_d = S_FETCH1;
      default:  state_d = S_RESET;
    endcase
  end

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) state_q <= S_RESET;
    else        state_q <= state_d;
  end

  // Field slices: [15:14]=DSS [13:12]=WRA [11:10]=SRA [9:8]=SRB [7:6]=SISE [5:4]=SALUB [3:0]=ALUA
  always_comb begin
    cw = '0;
    case (state_q)
      S_RESET: cw[B_CLR] = 1'b1;
      S_FETCH1: begin
        cw[11:10]    = 2'b11;
        cw[B_SMA]    = 1'b1;
        cw[B_MAR_EN] = 1'b1;
      end
      S_FETCH2: begin
        cw[11:10]    = 2'b11;
        cw[5:4]      = 2'b11;
        cw[3:0]      = ALU_ADD;
        cw[B_RF_RW]  = 1'b1;
        cw[13:12]    = 2'b11;
        cw[B_MFA]    = 1'b1;
        cw[B_RW_RAM] = 1'b1;
      end
      S_FETCH3: begin
        cw[B_MFA]    = 1'b1;
        cw[B_RW_RAM] = 1'b1;
        cw[B_IR_EN]  = 1'b1;
      end
      S_DP_REG, S_DP_IMM: begin
        cw[9:8]      = 2'b10;
        cw[B_SHT_EN] = 1'b1;
        cw[3:0]      = IR[24:21];
        cw[13:12]    = 2'b01;
        cw[B_SR_EN]  = IR[20];
        // TST/TEQ/CMP/CMN only update flags
        cw[B_RF_RW]  = (IR[24:23] != 2'b10);
        cw[B_SSOP]   = (state_q == S_DP_IMM);
        cw[B_STA]    = (state_q == S_DP_IMM);
      end
      S_ADDR: begin
        cw[B_ISE_EN] = 1'b1;
        cw[5:4]      = 2'b01;
        cw[3:0]      = IR[23] ? ALU_ADD : ALU_SUB;
        cw[B_MAR_EN] = 1'b1;
      end
      S_LOAD: begin
        cw[B_MFA]    = 1'b1;
        cw[B_RW_RAM] = 1'b1;
        cw[B_MDR_EN] = 1'b1;
      end
      S_WB: begin
        cw[B_RF_RW]  = 1'b1;
        cw[13:12]    = 2'b01;
        cw[15:14]    = 2'b01;
      end
      S_STORE: begin
        cw[9:8]      = 2'b01;
        cw[B_SSAB]   = 1'b1;
        cw[B_MDR_EN] = 1'b1;
        cw[B_MFA]    = 1'b1;
      end
      S_LINK: begin
        cw[11:10]    = 2'b11;
        cw[15:14]    = 2'b10;
        cw[13:12]    = 2'b10;
        cw[B_RF_RW]  = 1'b1;
      end
      S_BRANCH: begin
        cw[11:10]    = 2'b11;
        cw[B_ISE_EN] = 1'b1;
        cw[7:6]      = 2'b10;
        cw[5:4]      = 2'b01;
        cw[3:0]      = ALU_ADD;
        cw[B_RF_RW]  = 1'b1;
        cw[13:12]    = 2'b11;
      end
      default: cw = '0;
    endcase
  end

  assign CW = cw;

endmodule

// File: tb/tb_arm_control_unit.sv
// Bench for arm_control_unit: per-cycle CW check against a state-level model, plus hand-computed CW literals.
module tb_arm_control_unit;

  logic        CLK = 1'b0;
  logic        Reset = 1'b1;
  logic [31:0] IR = '0;
  logic        MFC = 1'b0;
  logic [3:0]  Flags = '0;
  logic [31:0] CW;

  int n_checks = 0;
  int n_fail = 0;
  int m_st = 0;
  bit model_on = 1'b0;

  typedef struct packed {
    logic mfa, rw_ram, salu, rf_rw, ssab, ssop, sma, sta;
    logic mar_en, sr_en, mdr_en, ir_en, sht_en, ise_en, sgn_en, clr;
    logic [1:0] dss, wra, sra, srb, sise, salub;
    logic [3:0] alua;
  } cw_t;

  arm_control_unit dut (
    .CLK(CLK), .Reset(Reset), .CW(CW), .IR(IR), .MFC(MFC), .Flags(Flags)
  );

  always #5 CLK = ~CLK;

  function automatic bit cond_true(logic [3:0] c, logic [3:0] f);
    bit fc = f[3], fn = f[2], fv = f[1], fz = f[0];
    case (c)
      0: return fz;          1: return !fz;
      2: return fc;          3: return !fc;
      4: return fn;          5: return !fn;
      6: return fv;          7: return !fv;
      8: return fc && !fz;   9: return !fc || fz;
      10: return fn == fv;   11: return fn != fv;
      12: return !fz && fn == fv;
      13: return fz || fn != fv;
      14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic int next_st(int s, logic [31:0] ir, logic [3:0] f, logic mfc);
    bit link;
`ifdef CU_BRANCH_LINK_EN
    link = ir[24];
`else
    link = 1'b0;
`endif
    case (s)
      0: return 1;
      1: return 2;
      2: return 3;
      3: return mfc ? 4 : 3;
      4: begin
        if (!cond_true(ir[31:28], f)) return 1;
        case (ir[27:25])
          3'b000: return 5;
          3'b001: return 6;
          3'b010: return 7;
          3'b101: return link ? 11 : 12;
          default: return 1;
        endcase
      end
      5, 6, 9, 12: return 1;
      7: return ir[20] ? 8 : 10;
      8: return mfc ? 9 : 8;
      10: return mfc ? 1 : 10;
      11: return 12;
      default: return 0;
    endcase
  endfunction

  function automatic logic [31:0] exp_cw(int s, logic [31:0] ir);
    cw_t c = '0;
    case (s)
      0: c.clr = 1;
      1: begin c.sra = 3; c.sma = 1; c.mar_en = 1; end
      2: begin c.sra = 3; c.salub = 3; c.alua = 4; c.rf_rw = 1; c.wra = 3; c.mfa = 1; c.rw_ram = 1; end
      3: begin c.mfa = 1; c.rw_ram = 1; c.ir_en = 1; end
      5, 6: begin
        c.srb = 2; c.sht_en = 1; c.alua = ir[24:21]; c.wra = 1; c.sr_en = ir[20];
        c.rf_rw = !(ir[24:21] >= 8 && ir[24:21] <= 11);
        if (s == 6) begin c.ssop = 1; c.sta = 1; end
      end
      7: begin c.ise_en = 1; c.salub = 1; c.alua = ir[23] ? 4'd4 : 4'd2; c.mar_en = 1; end
      8: begin c.mfa = 1; c.rw_ram = 1; c.mdr_en = 1; end
      9: begin c.rf_rw = 1; c.wra = 1; c.dss = 1; end
      10: begin c.srb = 1; c.ssab = 1; c.mdr_en = 1; c.mfa = 1; end
      11: begin c.sra = 3; c.dss = 2; c.wra = 2; c.rf_rw = 1; end
      12: begin c.sra = 3; c.ise_en = 1; c.sise = 2; c.salub = 1; c.alua = 4; c.rf_rw = 1; c.wra = 3; end
      default: c = '0;
    endcase
    return c;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: CW got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      m_st <= 0;
      model_on <= 1'b1;
    end else if (model_on) begin
      m_st <= next_st(m_st, IR, Flags, MFC);
    end
  end

  always @(negedge CLK) begin
    if (model_on) check($sformatf("model_s%0d", m_st), CW, exp_cw(m_st, IR));
  end

  task automatic tick();
    @(posedge CLK);
    #2;
  endtask

  localparam logic [31:0] CW_S0 = 32'h0001_0000;
  localparam logic [31:0] CW_S1 = 32'h0280_0C00;
  localparam logic [31:0] CW_S2 = 32'hD000_3C34;
  localparam logic [31:0] CW_S3 = 32'hC010_0000;

  // Enter with the unit in FETCH1; leaves it in DECODE.
  task automatic fetch(logic [31:0] ir, logic [3:0] f, int waits);
    IR = ir;
    Flags = f;
    tick(); check("fetch2", CW, CW_S2);
    tick(); check("fetch3", CW, CW_S3);
    for (int i = 0; i < waits; i++) begin
      tick(); check("fetch3_wait", CW, CW_S3);
    end
    MFC = 1'b1;
    tick(); check("decode", CW, 32'h0);
    MFC = 1'b0;
  endtask

  initial begin
    #1 Reset = 1'b0;
    #2 check("reset_async", CW, CW_S0);
    tick(); tick();
    Reset = 1'b1;
    check("reset_release", CW, CW_S0);
    tick(); check("fetch1", CW, CW_S1);
    check("fetch1_mar_sma", {30'h0, CW[25], CW[23]}, 32'h3);

    // ADD R1,R1,#1 with three memory wait cycles
    fetch(32'hE281_1001, 4'h0, 3);
    tick(); check("add_imm", CW, 32'h1508_1204);
    tick(); check("add_done", CW, CW_S1);

    // CMPEQ: Z clear skips, Z set executes as flag-only
    fetch(32'h0152_0003, 4'b0000, 0);
    tick(); check("cmpeq_skip", CW, CW_S1);
    fetch(32'h0152_0003, 4'b0001, 0);
    tick(); check("cmpeq_exec", CW, 32'h0048_120A);
    tick(); check("cmpeq_done", CW, CW_S1);

    // LDR R2,[R1,#4]
    fetch(32'hE591_2004, 4'h0, 1);
    tick(); check("ldr_addr", CW, 32'h0084_0014);
    tick(); check("ldr_load", CW, 32'hC020_0000);
    tick(); check("ldr_load_wait", CW, 32'hC020_0000);
    MFC = 1'b1;
    tick(); check("ldr_wb", CW, 32'h1000_5000);
    MFC = 1'b0;
    tick(); check("ldr_done", CW, CW_S1);

    // STR R2,[R1,#-4]
    fetch(32'hE501_2004, 4'h0, 0);
    tick(); check("str_addr_sub", CW, 32'h0084_0012);
    tick(); check("str_store", CW, 32'h8820_0100);
    MFC = 1'b1;
    tick(); check("str_done", CW, CW_S1);
    MFC = 1'b0;

    // BL
    fetch(32'hEBFF_FFFE, 4'h0, 0);
`ifdef CU_BRANCH_LINK_EN
    tick(); check("bl_link", CW, 32'h1000_AC00);
`endif
    tick(); check("bl_branch", CW, 32'h1004_3C94);
    tick(); check("bl_done", CW, CW_S1);

    // B (no link) goes straight to BRANCH in either build
    fetch(32'hEAFF_FFFE, 4'h0, 0);
    tick(); check("b_branch", CW, 32'h1004_3C94);
    tick(); check("b_done", CW, CW_S1);

    // Unsupported class (IR[27:25]=011) returns to fetch
    fetch(32'hE600_0000, 4'h0, 0);
    tick(); check("undef_class", CW, CW_S1);

    // Reset during a load memory wait aborts immediately
    fetch(32'hE591_2004, 4'h0, 0);
    tick(); check("abort_addr", CW, 32'h0084_0014);
    tick(); check("abort_load", CW, 32'hC020_0000);
    Reset = 1'b0;
    #1 check("abort_reset", CW, CW_S0);
    MFC = 1'b1;
    tick(); check("abort_hold", CW, CW_S0);
    MFC = 1'b0;
    Reset = 1'b1;
    tick(); check("abort_refetch", CW, CW_S1);

    // Condition-code sweep on a register ADD/SUBS; the model checks every cycle
    for (int c = 0; c < 16; c++) begin
      for (int k = 0; k < 8; k++) begin
        logic [3:0] fl;
        fl = (k == 0) ? 4'h0 : (k == 1) ? 4'h1 : (k == 2) ? 4'h2 : (k == 3) ? 4'h4 :
             (k == 4) ? 4'h8 : (k == 5) ? 4'h5 : (k == 6) ? 4'hA : 4'hF;
        fetch({c[3:0], 3'b000, (k[0] ? 4'b0010 : 4'b0100), k[1], 20'h21003}, fl, 0);
        tick();
        if (CW == 32'h0) check("sweep_left_decode", CW, CW_S1);
        if (CW != CW_S1) tick();
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running, expected done");
    $fatal(1, "timeout");
  end

endmodule
